// File: rtl/poly_diff_engine_disp_if.sv
// Bus bundle for poly_diff_engine_disp: run request, table load port, status,
// held result and the multiplexed seven-segment drive.
interface poly_diff_engine_disp_if #(
    parameter int W      = 16,
    parameter int NW     = 6,
    parameter int DIGITS = W / 4
);
    logic [NW-1:0]     n;
    logic              start;
    logic              load_en;
    logic [2:0]        load_idx;
    logic [W-1:0]      load_data;
    logic              busy;
    logic              done_tick;
    logic              overflow;
    logic [W-1:0]      result;
    logic [DIGITS-1:0] an;
    logic [7:0]        sseg;

    modport master (
        output n, start, load_en, load_idx, load_data,
        input  busy, done_tick, overflow, result, an, sseg
    );

    modport slave (
        input  n, start, load_en, load_idx, load_data,
        output busy, done_tick, overflow, result, an, sseg
    );
endinterface

// File: rtl/poly_diff_engine_disp.sv
// Finite-difference polynomial evaluator with hex seven-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
//
// state | meaning
// IDLE  | waiting for start; table writable
// INIT  | copy table into working registers, clear overflow
// ITER  | one difference-propagation step per cycle
// DONE  | result captured, done_tick high
module poly_diff_engine_disp #(
    parameter int W            = 16,
    parameter int ORDER        = 3,
    parameter int NW           = 6,
    parameter int REFRESH_BITS = 17
) (
    input  logic                   clk,
    input  logic                   reset,
    poly_diff_engine_disp_if.slave bus
);
    localparam int DIGITS   = W / 4;
    localparam int SEL_BITS = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, INIT, ITER, DONE} state_t;

    state_t                  state, state_nx;
    logic [W-1:0]            tbl [ORDER+1];
    logic [W-1:0]            w   [ORDER+1];
    logic [W:0]              sum [ORDER];
    logic                    carry;
    logic [NW-1:0]           cnt;
    logic [W-1:0]            result_q;
    logic                    overflow_q;
    logic [REFRESH_BITS-1:0] rcnt;
    logic [SEL_BITS-1:0]     sel;
    logic [3:0]              nib;
    logic [DIGITS-1:0]       an_c;
    logic [7:0]              seg_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = INIT;
            INIT:    state_nx = (cnt == '0) ? DONE : ITER;
            ITER:    if (cnt == NW'(1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // All stages add in parallel from pre-edge values; carry from any stage flags overflow.
    always_comb begin
        carry = 1'b0;
        for (int i = 0; i < ORDER; i++) begin
            sum[i] = {1'b0, w[i]} + {1'b0, w[i+1]};
            carry  = carry | sum[i][W];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= ORDER; i++) begin
                tbl[i] <= (i == 1 || i == 2) ? W'(i) : '0;
                w[i]   <= '0;
            end
            cnt        <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load_en) begin
                        for (int i = 0; i <= ORDER; i++)
                            if (bus.load_idx == 3'(i)) tbl[i] <= bus.load_data;
                    end
                    if (bus.start) cnt <= bus.n;
                end
                INIT: begin
                    for (int i = 0; i <= ORDER; i++) w[i] <= tbl[i];
                    overflow_q <= 1'b0;
                    if (cnt == '0) result_q <= tbl[0];
                end
                ITER: begin
                    for (int i = 0; i < ORDER; i++) w[i] <= sum[i][W-1:0];
                    cnt <= cnt - NW'(1);
                    if (carry) overflow_q <= 1'b1;
                    if (cnt == NW'(1)) result_q <= sum[0][W-1:0];
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done_tick = (state == DONE);
    assign bus.overflow  = overflow_q;
    assign bus.result    = result_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rcnt <= '0;
        else        rcnt <= rcnt + 1'b1;
    end

    assign sel = rcnt[REFRESH_BITS-1 -: SEL_BITS];
    assign nib = result_q[{sel, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    logic [SEL_BITS-1:0] msn;

    always_comb begin
        msn = '0;
        for (int d = 1; d < DIGITS; d++)
            if (result_q[4*d +: 4] != 4'h0) msn = SEL_BITS'(d);
    end
`endif

    always_comb begin
        an_c      = '1;
        an_c[sel] = 1'b0;
        seg_c     = 8'hFF;
        case (nib)
            4'h0: seg_c = 8'hC0;
            4'h1: seg_c = 8'hF9;
            4'h2: seg_c = 8'hA4;
            4'h3: seg_c = 8'hB0;
            4'h4: seg_c = 8'h99;
            4'h5: seg_c = 8'h92;
            4'h6: seg_c = 8'h82;
            4'h7: seg_c = 8'hF8;
            4'h8: seg_c = 8'h80;
            4'h9: seg_c = 8'h90;
            4'hA: seg_c = 8'h88;
            4'hB: seg_c = 8'h83;
            4'hC: seg_c = 8'hC6;
            4'hD: seg_c = 8'hA1;
            4'hE: seg_c = 8'h86;
            4'hF: seg_c = 8'h8E;
            default: seg_c = 8'hFF;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if (sel > msn) begin
            an_c  = '1;
            seg_c = 8'hFF;
        end
`endif
    end

    assign bus.an   = an_c;
    assign bus.sseg = seg_c;
endmodule

// File: tb/tb_poly_diff_engine_disp.sv
// Directed bench for poly_diff_engine_disp (W=16, ORDER=3) with a shortened
// refresh counter so every display slot is reached quickly.
module tb_poly_diff_engine_disp;
    localparam int W  = 16;
    localparam int NW = 6;
    localparam int RB = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;
    logic [RB-1:0] rc;

    poly_diff_engine_disp_if #(.W(W), .NW(NW)) bus ();

    poly_diff_engine_disp #(.W(W), .ORDER(3), .NW(NW), .REFRESH_BITS(RB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Independent copy of the free-running refresh count to know which slot is live.
    always @(posedge clk or negedge reset) begin
        if (!reset) rc <= '0;
        else        rc <= rc + 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [2:0] idx, input logic [15:0] data);
        bus.load_en   = 1'b1;
        bus.load_idx  = idx;
        bus.load_data = data;
        @(negedge clk);
        bus.load_en   = 1'b0;
    endtask

    // Starts a run at the current negedge; optionally pokes start/load_en mid-run.
    task automatic run(input string tag, input logic [5:0] nv, input int lat_exp,
                       input logic [15:0] res_exp, input logic ovf_exp, input bit disturb);
        int lat;
        int busy_cnt;
        int extra;
        lat      = 0;
        busy_cnt = 0;
        extra    = 0;
        bus.n     = nv;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.load_en = 1'b0;
        lat = 1;
        while (!bus.done_tick && lat < 200) begin
            if (bus.busy) busy_cnt++;
            if (disturb && lat == 2) begin
                bus.start     = 1'b1;
                bus.n         = 6'd9;
                bus.load_en   = 1'b1;
                bus.load_idx  = 3'd0;
                bus.load_data = 16'h1234;
            end
            if (disturb && lat == 3) begin
                bus.start   = 1'b0;
                bus.load_en = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        if (bus.busy) busy_cnt++;
        chk({tag, "_latency"}, lat, lat_exp);
        chk({tag, "_result"}, bus.result, res_exp);
        chk({tag, "_overflow"}, bus.overflow, ovf_exp);
        chk({tag, "_busy_cycles"}, busy_cnt, lat_exp);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done_tick) extra++;
        end
        chk({tag, "_extra_done"}, extra, 0);
        chk({tag, "_idle"}, bus.busy, 1'b0);
    endtask

    task automatic disp(input string tag, input int d, input logic [3:0] an_exp,
                        input logic [7:0] seg_exp);
        int waited;
        waited = 0;
        while (int'(rc[RB-1 -: 2]) != d && waited < 600) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_slot_reached"}, (waited < 600), 1'b1);
        chk({tag, "_an"}, bus.an, an_exp);
        chk({tag, "_sseg"}, bus.sseg, seg_exp);
    endtask

    initial begin
        int stray;
        bus.n         = '0;
        bus.start     = 1'b0;
        bus.load_en   = 1'b0;
        bus.load_idx  = '0;
        bus.load_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done_tick, 1'b0);
        chk("rst_overflow", bus.overflow, 1'b0);
        chk("rst_result", bus.result, 16'h0000);
        chk("rst_an", bus.an, 4'b1110);
        chk("rst_sseg", bus.sseg, 8'hC0);
        reset = 1'b1;
        @(negedge clk);

        // Default table gives n^2.
        run("sq5", 6'd5, 7, 16'd25, 1'b0, 1'b0);
        disp("sq5_d0", 0, 4'b1110, 8'h90);
        disp("sq5_d1", 1, 4'b1101, 8'hF9);

        // f = 2n^3 + 3n^2 - 4n + 5
        load(3'd0, 16'd5);
        load(3'd1, 16'd1);
        load(3'd2, 16'd18);
        load(3'd3, 16'd12);
        load(3'd7, 16'hBEEF);
        run("cub3", 6'd3, 5, 16'h004A, 1'b0, 1'b0);
        disp("cub3_d0", 0, 4'b1110, 8'h88);
        disp("cub3_d1", 1, 4'b1101, 8'h99);
`ifdef LEADING_ZERO_BLANK_EN
        disp("cub3_d2", 2, 4'b1111, 8'hFF);
`else
        disp("cub3_d2", 2, 4'b1011, 8'hC0);
`endif

        run("cub0", 6'd0, 2, 16'd5, 1'b0, 1'b0);

        // start and load_en during ITER must be ignored
        run("cub2_busy", 6'd2, 4, 16'd25, 1'b0, 1'b1);
        run("cub0_after", 6'd0, 2, 16'd5, 1'b0, 1'b0);

        // Overflow; last write coincides with start
        load(3'd1, 16'd1);
        load(3'd2, 16'd0);
        load(3'd3, 16'd0);
        bus.load_en   = 1'b1;
        bus.load_idx  = 3'd0;
        bus.load_data = 16'hFFFF;
        run("ovf1", 6'd1, 3, 16'h0000, 1'b1, 1'b0);
        run("ovf_clear", 6'd0, 2, 16'hFFFF, 1'b0, 1'b0);

        // Reset in the middle of a long run
        bus.n     = 6'd40;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_busy_before", bus.busy, 1'b1);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_done", bus.done_tick, 1'b0);
        chk("mid_rst_result", bus.result, 16'h0000);
        chk("mid_rst_an", bus.an, 4'b1110);
        @(negedge clk);
        reset = 1'b1;
        stray = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.done_tick) stray++;
        end
        chk("mid_rst_no_done", stray, 0);
        run("sq4", 6'd4, 6, 16'd16, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
